// File: rtl/if2id_queue.sv
// rtl/if2id_queue.sv - IF->ID instruction queue: DEPTH-entry FIFO of {pc, instr} with flush
module if2id_queue #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = 3
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         flush_i,
    input  logic                         fetch_valid_i,
    output logic                         ready_o,
    input  logic [ADDR_WIDTH-1:0]        pc_i,
    input  logic [INSTR_WIDTH-1:0]       instr_i,
    output logic                         valid_o,
    input  logic                         decode_ready_i,
    output logic [ADDR_WIDTH-1:0]        pc_o,
    output logic [INSTR_WIDTH-1:0]       instr_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         almost_full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = ADDR_WIDTH + INSTR_WIDTH;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic [ENT_W-1:0] head;

    // ready_o depends only on occupancy, never on decode_ready_i
    assign ready_o       = rstn_i & (count_q != CNT_W'(DEPTH));
    assign valid_o       = (count_q != '0);
    assign push          = fetch_valid_i & ready_o & ~flush_i;
    assign pop           = valid_o & decode_ready_i & ~flush_i;
    assign head          = mem_q[rd_ptr_q];
    assign pc_o          = valid_o ? head[ENT_W-1:INSTR_WIDTH] : '0;
    assign instr_o       = valid_o ? head[INSTR_WIDTH-1:0] : '0;
    assign count_o       = count_q;
    assign almost_full_o = (count_q >= CNT_W'(AFULL_LEVEL));

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q alone
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {pc_i, instr_i};
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(push && count_q == CNT_W'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(pop && count_q == '0));
    a_count_range: assert property (@(posedge clk_i) disable iff (!rstn_i)
        count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_if2id_queue.sv
// tb/tb_if2id_queue.sv - scoreboard bench for if2id_queue: directed scenarios then random traffic
module tb_if2id_queue;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          flush = 1'b0;
    logic          fv = 1'b0;
    logic          dr = 1'b0;
    logic [AW-1:0] pc_in = '0;
    logic [IW-1:0] instr_in = '0;
    logic          ready, valid, afull;
    logic [AW-1:0] pc_out;
    logic [IW-1:0] instr_out;
    logic [CW-1:0] count;

    int vectors = 0;
    int errors  = 0;
    logic [AW+IW-1:0] exp_q[$];
    int push_pend = 0;
    logic [AW-1:0] next_pc = '0;

    if2id_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .fetch_valid_i(fv), .ready_o(ready),
        .pc_i(pc_in), .instr_i(instr_in), .valid_o(valid), .decode_ready_i(dr),
        .pc_o(pc_out), .instr_o(instr_out), .count_o(count), .almost_full_o(afull)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; an accepted payload is queued as the expected future output
    task automatic drive(input logic f, input logic d, input logic fl);
        @(posedge clk);
        #1;
        fv       = f;
        dr       = d;
        flush    = fl;
        pc_in    = next_pc;
        instr_in = $urandom;
        if (rstn && f && !fl && exp_q.size() < DEPTH) begin
            exp_q.push_back({pc_in, instr_in});
            push_pend = 1;
            next_pc   = next_pc + 32'd4;
        end
    endtask

    // Monitor: checks visible state against the model, then retires pops and flushes
    always @(negedge clk) begin
        int sz;
        sz = exp_q.size() - push_pend;
        if (!rstn) begin
            chk("rst_valid", valid, 0);
            chk("rst_ready", ready, 0);
            chk("rst_count", count, 0);
            chk("rst_pc", pc_out, 0);
            exp_q.delete();
        end else begin
            chk("count", count, sz);
            chk("valid", valid, sz != 0);
            chk("ready", ready, sz < DEPTH);
            chk("almost_full", afull, sz >= AFULL);
            if (sz > 0) begin
                chk("head_pc", pc_out, exp_q[0][AW+IW-1:IW]);
                chk("head_instr", instr_out, exp_q[0][IW-1:0]);
            end else begin
                chk("idle_pc", pc_out, 0);
                chk("idle_instr", instr_out, 0);
            end
            if (flush) exp_q.delete();
            else if (sz > 0 && dr) void'(exp_q.pop_front());
        end
        push_pend = 0;
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // fill with decode stalled, then attempt one push while full
        next_pc = '0;
        repeat (4) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // drain in order
        repeat (4) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // simultaneous push/pop at count 2 across pointer wrap
        repeat (2) drive(1'b1, 1'b0, 1'b0);
        repeat (10) drive(1'b1, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 1'b0);

        // flush with push and pop also requested
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);

        // async reset with 3 entries queued
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        fv   = 1'b0;
        dr   = 1'b0;
        rstn = 1'b0;
        #1;
        chk("async_rst_valid", valid, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_ready", ready, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        #1 chk("post_rst_ready", ready, 1);
        chk("post_rst_valid", valid, 0);

        // random traffic
        for (int i = 0; i < 10000; i++)
            drive(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(99) < 5);
        drive(1'b0, 1'b1, 1'b0);
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
